// File: rtl/rv32i_wb_uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv32i_wb_uart_pkg                                                     |
// | Shared types and framing constants for the writeback UART tracer.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package rv32i_wb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 2;

  // Bytes leave the word high byte first.
  function automatic logic [BITS_PER_BYTE-1:0] word_byte(
    input logic [BITS_PER_BYTE*BYTES_PER_WORD-1:0] word,
    input logic                                    low_sel
  );
    return low_sel ? word[BITS_PER_BYTE-1:0] : word[2*BITS_PER_BYTE-1:BITS_PER_BYTE];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_wb_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv32i_wb_fifo                                                         |
// | Synchronous FIFO with occupancy count; push accepted when full if a   |
// | pop happens in the same cycle.                                        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rv32i_wb_fifo
  import rv32i_wb_uart_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rv32i_wb_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv32i_wb_uart_tx                                                      |
// | Captures changes on the core writeback bus and streams each word as   |
// | two 8N1 UART bytes (high byte first) on a single pad.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rv32i_wb_uart_tx
  import rv32i_wb_uart_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CLK_DIV    = 868,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              RN,
  input  logic [DATA_W-1:0] wb_out,
  input  logic              capture_en,
  input  logic              clr_ovf,
  output logic              tx,
  output logic              tx_oeb,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] c_BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        c_LAST_BIT    = 3'(BITS_PER_BYTE - 1);

  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic              r_ovf;

  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic              r_byte_sel;
  logic [DATA_W-1:0] r_shreg;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_count;
  logic              w_baud_zero;
  logic [7:0]        w_cur_byte;
  logic              w_tx;

  assign w_push      = capture_en & (~r_prev_valid | (wb_out != r_prev));
  assign w_pop       = (r_state == IDLE) & ~w_empty;
  assign w_baud_zero = (r_baud == '0);
  assign w_cur_byte  = word_byte(r_shreg, r_byte_sel);

  rv32i_wb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (RN),
    .i_push  (w_push),
    .i_wdata (wb_out),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (capture_en) begin
      r_prev       <= wb_out;
      r_prev_valid <= 1'b1;
    end
  end

  // A drop sets the flag even when a clear arrives on the same edge.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      r_ovf <= 1'b0;
    end else if (w_push & w_full & ~w_pop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_shreg    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shreg    <= w_rdata;
            r_byte_sel <= 1'b0;
            r_baud     <= c_BAUD_RELOAD;
            r_state    <= START;
          end
        end
        START: begin
          if (w_baud_zero) begin
            r_baud    <= c_BAUD_RELOAD;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_baud_zero) begin
            r_baud <= c_BAUD_RELOAD;
            if (r_bit_idx == c_LAST_BIT) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_baud_zero) begin
            if (!r_byte_sel) begin
              r_byte_sel <= 1'b1;
              r_baud     <= c_BAUD_RELOAD;
              r_state    <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - BAUD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line level is a pure decode of registered state, so reset drives it high at once.
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_cur_byte[r_bit_idx];
      default: w_tx = 1'b1;
    endcase
  end

  assign tx         = w_tx;
  assign tx_oeb     = 1'b0;
  assign busy       = (r_state != IDLE) | ~w_empty;
  assign overflow   = r_ovf;
  assign fifo_count = w_count;

endmodule
`default_nettype wire
